jtag_tap_oversampled: RTL and testbench

- JTAG TAP controller that consumes the pin-level JTAG signals driven by the simulation JTAG DPI model (or board pins) and runs entirely on the SoC system clock.
- Oversamples TCK/TMS/TDI/TRST_n and implements the IEEE 1149.1 16-state TAP with IDCODE, BYPASS and one user data register.
- Exposes capture/update strobes and data so a downstream debug-module interface can consume DR scans without a separate TCK clock domain.

---
 rtl/jtag_pkg.sv | 61 ++++++
 rtl/jtag_in_sync.sv | 30 +++
 rtl/jtag_tap_oversampled.sv | 184 ++++++++++++++++++
 tb/tb_jtag_tap_oversampled.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state encoding, instruction codes, IR capture pattern and the
// standard 1149.1 next-state function.
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'h0,
        RUN_TEST_IDLE    = 4'h1,
        SELECT_DR_SCAN   = 4'h2,
        CAPTURE_DR       = 4'h3,
        SHIFT_DR         = 4'h4,
        EXIT1_DR         = 4'h5,
        PAUSE_DR         = 4'h6,
        EXIT2_DR         = 4'h7,
        UPDATE_DR        = 4'h8,
        SELECT_IR_SCAN   = 4'h9,
        CAPTURE_IR       = 4'hA,
        SHIFT_IR         = 4'hB,
        EXIT1_IR         = 4'hC,
        PAUSE_IR         = 4'hD,
        EXIT2_IR         = 4'hE,
        UPDATE_IR        = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

    localparam logic [4:0]  IR_IDCODE      = 5'h01;
    localparam logic [4:0]  IR_USER        = 5'h11;
    localparam logic [4:0]  IR_BYPASS      = 5'h1F;
    localparam logic [4:0]  IR_CAPTURE     = 5'b00101;
    localparam logic [31:0] IDCODE_DEFAULT = 32'h04F5484D;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = TEST_LOGIC_RESET;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_in_sync.sv
// Multi-stage synchronizer for a vector of asynchronous inputs, with a per-bit reset value.
module jtag_in_sync #(
    parameter int unsigned      Width    = 4,
    parameter int unsigned      Stages   = 2,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Stages-1:0][Width-1:0] sync_q;
    logic [Stages-1:0][Width-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[Stages-2:0], d_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {Stages{ResetVal}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/jtag_tap_oversampled.sv
// IEEE 1149.1 TAP running on the system clock: JTAG pins are oversampled and TCK edges become
// single-clk events, so DR capture/update reach the debug logic without a TCK clock domain.
module jtag_tap_oversampled
    import jtag_pkg::*;
#(
    parameter int unsigned IrWidth    = 5,
    parameter logic [31:0] IdCode     = IDCODE_DEFAULT,
    parameter int unsigned DrWidth    = 41,
    parameter int unsigned SyncStages = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               jtag_tck_i,
    input  logic               jtag_tms_i,
    input  logic               jtag_tdi_i,
    input  logic               jtag_trst_ni,
    output logic               jtag_tdo_o,
    output logic               jtag_tdo_oe_o,
    input  logic [DrWidth-1:0] dr_capture_data_i,
    output logic               dr_capture_o,
    output logic               dr_update_o,
    output logic [DrWidth-1:0] dr_update_data_o,
    output logic [IrWidth-1:0] ir_o,
    output logic [3:0]         tap_state_o
);

    localparam int unsigned PinW = 4;

    logic [PinW-1:0] pins_s;
    logic            tck_s, tms_s, tdi_s, trst_n_s;
    logic            tck_rise_c, tck_fall_c;
    dr_sel_e         dr_sel_c;

    tap_state_e        state_q, state_d;
    logic [IrWidth-1:0] ir_q, ir_d;
    logic [IrWidth-1:0] ir_sr_q, ir_sr_d;
    logic [DrWidth-1:0] dr_sr_q, dr_sr_d;
    logic [DrWidth-1:0] dr_update_data_q, dr_update_data_d;
    logic               tck_prev_q, tck_prev_d;
    logic               tdo_q, tdo_d;
    logic               tdo_oe_q, tdo_oe_d;
    logic               dr_capture_q, dr_capture_d;
    logic               dr_update_q, dr_update_d;

    // TRST_n resets to 0 so the TAP stays in reset until the pin has propagated.
    jtag_in_sync #(
        .Width    (PinW),
        .Stages   (SyncStages),
        .ResetVal (4'b0000)
    ) u_in_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({jtag_trst_ni, jtag_tdi_i, jtag_tms_i, jtag_tck_i}),
        .q_o   (pins_s)
    );

    assign tck_s    = pins_s[0];
    assign tms_s    = pins_s[1];
    assign tdi_s    = pins_s[2];
    assign trst_n_s = pins_s[3];

    assign tck_rise_c = tck_s & ~tck_prev_q;
    assign tck_fall_c = ~tck_s & tck_prev_q;

    always_comb begin
        case (ir_q)
            IrWidth'(IR_IDCODE): dr_sel_c = DR_IDCODE;
            IrWidth'(IR_USER):   dr_sel_c = DR_USER;
            IrWidth'(IR_BYPASS): dr_sel_c = DR_BYPASS;
            default:             dr_sel_c = DR_BYPASS;
        endcase
    end

    // TAP next state, IR/DR capture and shift on TCK rise; TDO and updates on TCK fall.
    always_comb begin
        state_d          = state_q;
        ir_d             = ir_q;
        ir_sr_d          = ir_sr_q;
        dr_sr_d          = dr_sr_q;
        dr_update_data_d = dr_update_data_q;
        tck_prev_d       = tck_s;
        tdo_d            = tdo_q;
        tdo_oe_d         = tdo_oe_q;
        dr_capture_d     = 1'b0;
        dr_update_d      = 1'b0;

        if (!trst_n_s) begin
            state_d  = TEST_LOGIC_RESET;
            ir_d     = IrWidth'(IR_IDCODE);
            ir_sr_d  = '0;
            dr_sr_d  = '0;
            tdo_d    = 1'b0;
            tdo_oe_d = 1'b0;
        end else begin
            if (state_q == TEST_LOGIC_RESET) begin
                ir_d = IrWidth'(IR_IDCODE);
            end

            if (tck_rise_c) begin
                state_d = tap_next(state_q, tms_s);
                case (state_q)
                    CAPTURE_IR: ir_sr_d = IrWidth'(IR_CAPTURE);
                    SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[IrWidth-1:1]};
                    CAPTURE_DR: begin
                        case (dr_sel_c)
                            DR_IDCODE: dr_sr_d = DrWidth'(IdCode);
                            DR_USER: begin
                                dr_sr_d      = dr_capture_data_i;
                                dr_capture_d = 1'b1;
                            end
                            default:   dr_sr_d = '0;
                        endcase
                    end
                    SHIFT_DR: begin
                        case (dr_sel_c)
                            DR_IDCODE: dr_sr_d = DrWidth'({tdi_s, dr_sr_q[31:1]});
                            DR_USER:   dr_sr_d = {tdi_s, dr_sr_q[DrWidth-1:1]};
                            default:   dr_sr_d = DrWidth'(tdi_s);
                        endcase
                    end
                    default: ;
                endcase
            end

            if (tck_fall_c) begin
                tdo_d    = 1'b0;
                tdo_oe_d = 1'b0;
                case (state_q)
                    SHIFT_IR: begin
                        tdo_d    = ir_sr_q[0];
                        tdo_oe_d = 1'b1;
                    end
                    SHIFT_DR: begin
                        tdo_d    = dr_sr_q[0];
                        tdo_oe_d = 1'b1;
                    end
                    UPDATE_IR: ir_d = ir_sr_q;
                    UPDATE_DR: begin
                        if (dr_sel_c == DR_USER) begin
                            dr_update_data_d = dr_sr_q;
                            dr_update_d      = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= TEST_LOGIC_RESET;
            ir_q             <= IrWidth'(IR_IDCODE);
            ir_sr_q          <= '0;
            dr_sr_q          <= '0;
            dr_update_data_q <= '0;
            tck_prev_q       <= 1'b0;
            tdo_q            <= 1'b0;
            tdo_oe_q         <= 1'b0;
            dr_capture_q     <= 1'b0;
            dr_update_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            ir_q             <= ir_d;
            ir_sr_q          <= ir_sr_d;
            dr_sr_q          <= dr_sr_d;
            dr_update_data_q <= dr_update_data_d;
            tck_prev_q       <= tck_prev_d;
            tdo_q            <= tdo_d;
            tdo_oe_q         <= tdo_oe_d;
            dr_capture_q     <= dr_capture_d;
            dr_update_q      <= dr_update_d;
        end
    end

    assign jtag_tdo_o       = tdo_q;
    assign jtag_tdo_oe_o    = tdo_oe_q;
    assign dr_capture_o     = dr_capture_q;
    assign dr_update_o      = dr_update_q;
    assign dr_update_data_o = dr_update_data_q;
    assign ir_o             = ir_q;
    assign tap_state_o      = state_q;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Self-checking bench for jtag_tap_oversampled: directed scans plus randomized scans and TMS walks
// checked against a bit-queue model of the scan chain and a table model of the TAP diagram.
module tb_jtag_tap_oversampled;
    import jtag_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        tck, tms, tdi, trst_n;
    logic [40:0] cap_data;
    logic        tdo, tdo_oe, dr_capture, dr_update;
    logic [40:0] upd_data;
    logic [4:0]  ir;
    logic [3:0]  tap_state;

    always #5 clk = ~clk;

    jtag_tap_oversampled dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .jtag_tck_i        (tck),
        .jtag_tms_i        (tms),
        .jtag_tdi_i        (tdi),
        .jtag_trst_ni      (trst_n),
        .jtag_tdo_o        (tdo),
        .jtag_tdo_oe_o     (tdo_oe),
        .dr_capture_data_i (cap_data),
        .dr_capture_o      (dr_capture),
        .dr_update_o       (dr_update),
        .dr_update_data_o  (upd_data),
        .ir_o              (ir),
        .tap_state_o       (tap_state)
    );

    int unsigned pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    int unsigned cap_cnt = 0, upd_cnt = 0, b2b_cnt = 0;
    logic        cap_prev = 1'b0, upd_prev = 1'b0;
    int unsigned lo_h, hi_h;
    tap_state_e  m_state;
    logic [40:0] exp_upd;

    // Pulse bookkeeping: totals and any pulse held for two consecutive clks.
    always @(posedge clk) begin
        if (dr_capture) cap_cnt <= cap_cnt + 1;
        if (dr_update)  upd_cnt <= upd_cnt + 1;
        if ((dr_capture && cap_prev) || (dr_update && upd_prev)) b2b_cnt <= b2b_cnt + 1;
        cap_prev <= dr_capture;
        upd_prev <= dr_update;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The 1149.1 state diagram as a lookup of {next if TMS=0, next if TMS=1}.
    function automatic tap_state_e model_next(input tap_state_e s, input logic m);
        tap_state_e t0, t1;
        case (s)
            TEST_LOGIC_RESET: begin t0 = RUN_TEST_IDLE;  t1 = TEST_LOGIC_RESET; end
            RUN_TEST_IDLE:    begin t0 = RUN_TEST_IDLE;  t1 = SELECT_DR_SCAN;   end
            SELECT_DR_SCAN:   begin t0 = CAPTURE_DR;     t1 = SELECT_IR_SCAN;   end
            CAPTURE_DR:       begin t0 = SHIFT_DR;       t1 = EXIT1_DR;         end
            SHIFT_DR:         begin t0 = SHIFT_DR;       t1 = EXIT1_DR;         end
            EXIT1_DR:         begin t0 = PAUSE_DR;       t1 = UPDATE_DR;        end
            PAUSE_DR:         begin t0 = PAUSE_DR;       t1 = EXIT2_DR;         end
            EXIT2_DR:         begin t0 = SHIFT_DR;       t1 = UPDATE_DR;        end
            UPDATE_DR:        begin t0 = RUN_TEST_IDLE;  t1 = SELECT_DR_SCAN;   end
            SELECT_IR_SCAN:   begin t0 = CAPTURE_IR;     t1 = TEST_LOGIC_RESET; end
            CAPTURE_IR:       begin t0 = SHIFT_IR;       t1 = EXIT1_IR;         end
            SHIFT_IR:         begin t0 = SHIFT_IR;       t1 = EXIT1_IR;         end
            EXIT1_IR:         begin t0 = PAUSE_IR;       t1 = UPDATE_IR;        end
            PAUSE_IR:         begin t0 = PAUSE_IR;       t1 = EXIT2_IR;         end
            EXIT2_IR:         begin t0 = SHIFT_IR;       t1 = UPDATE_IR;        end
            default:          begin t0 = RUN_TEST_IDLE;  t1 = SELECT_DR_SCAN;   end
        endcase
        return m ? t1 : t0;
    endfunction

    // Scan chain as a bit queue: captured bits come out first, then the TDI stream.
    function automatic void dr_model(input logic [63:0] cap, input int len, input logic [63:0] din,
                                     input int n, output logic [63:0] out, output logic [63:0] upd);
        bit q[$];
        q = {};
        for (int i = 0; i < len; i++) q.push_back(cap[i]);
        for (int i = 0; i < n; i++) q.push_back(din[i]);
        out = '0;
        upd = '0;
        for (int i = 0; i < n; i++) out[i] = q[i];
        for (int i = 0; i < len; i++) upd[i] = q[n + i];
    endfunction

    task automatic tck_step(input logic t_ms, input logic t_di, output logic t_do);
        logic shifting;
        tms = t_ms;
        tdi = t_di;
        repeat (lo_h) @(negedge clk);
        t_do     = tdo;
        shifting = (m_state == SHIFT_IR) || (m_state == SHIFT_DR);
        chk("tdo_oe", {63'd0, tdo_oe}, {63'd0, shifting});
        if (!shifting) chk("tdo_idle", {63'd0, tdo}, 64'd0);
        tck     = 1'b1;
        m_state = model_next(m_state, t_ms);
        repeat (hi_h) @(negedge clk);
        chk("tap_state", {60'd0, tap_state}, {60'd0, m_state});
        tck = 1'b0;
    endtask

    task automatic tms_reset();
        logic b;
        for (int i = 0; i < 5; i++) tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
    endtask

    task automatic ir_scan(input logic [4:0] ir_in, output logic [4:0] ir_out);
        logic b;
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck_step(i == 4, ir_in[i], b);
            ir_out[i] = b;
        end
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
    endtask

    task automatic dr_scan(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic b;
        dout = '0;
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tck_step(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
    endtask

    initial begin
        logic [4:0]  ir_out, ir_sel;
        logic [63:0] dout, exp_out, exp_reg, din;
        logic        b;
        int          n, len, lat;
        int unsigned cap_base, upd_base;

        rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1;
        cap_data = 41'h1_2345_6789_A;
        lo_h = 4; hi_h = 4;
        m_state = TEST_LOGIC_RESET;
        exp_upd = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", {60'd0, tap_state}, {60'd0, TEST_LOGIC_RESET});
        chk("rst_ir", {59'd0, ir}, 64'h01);
        chk("rst_tdo", {62'd0, tdo, tdo_oe}, 64'd0);
        chk("rst_pulses", {62'd0, dr_capture, dr_update}, 64'd0);
        chk("rst_upd_data", {23'd0, upd_data}, 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // IDCODE read and IR capture pattern.
        tms_reset();
        chk("ir_after_tlr", {59'd0, ir}, 64'h01);
        dr_scan(64'd0, 32, dout);
        chk("idcode", dout, 64'h04F5484D);
        ir_scan(5'h01, ir_out);
        chk("ir_capture", {59'd0, ir_out}, 64'h05);

        // BYPASS and an illegal code behave identically.
        ir_scan(5'h1F, ir_out);
        chk("ir_bypass", {59'd0, ir}, 64'h1F);
        dr_scan(64'h0A5, 9, dout);
        chk("bypass_tdo", dout, 64'h14A);
        ir_scan(5'h07, ir_out);
        chk("ir_illegal", {59'd0, ir}, 64'h07);
        dr_scan(64'h0A5, 9, dout);
        chk("illegal_tdo", dout, 64'h14A);

        // USER capture/update.
        cap_base = cap_cnt; upd_base = upd_cnt;
        ir_scan(5'h11, ir_out);
        dr_scan(64'h0_DEAD_BEEF_1, 41, dout);
        exp_upd = 41'h0_DEAD_BEEF_1;
        chk("user_tdo", dout, 64'h1_2345_6789_A);
        chk("user_upd_data", {23'd0, upd_data}, 64'h0_DEAD_BEEF_1);
        chk("user_cap_cnt", 64'(cap_cnt - cap_base), 64'd1);
        chk("user_upd_cnt", 64'(upd_cnt - upd_base), 64'd1);

        // Randomized scans with random TCK phases down to the minimum legal width.
        for (int it = 0; it < 8; it++) begin
            lo_h = $urandom_range(7, 3);
            hi_h = $urandom_range(7, 3);
            case ($urandom_range(3, 0))
                0:       ir_sel = 5'h01;
                1:       ir_sel = 5'h11;
                2:       ir_sel = 5'h1F;
                default: ir_sel = 5'($urandom());
            endcase
            cap_data = {9'($urandom()), 32'($urandom())};
            din      = {32'($urandom()), 32'($urandom())};
            len      = (ir_sel == 5'h01) ? 32 : (ir_sel == 5'h11) ? 41 : 1;
            n        = len + int'($urandom_range(8, 0));
            if (ir_sel == 5'h01) dr_model(64'h04F5484D, len, din, n, exp_out, exp_reg);
            else if (ir_sel == 5'h11) dr_model({23'd0, cap_data}, len, din, n, exp_out, exp_reg);
            else dr_model(64'd0, len, din, n, exp_out, exp_reg);
            ir_scan(ir_sel, ir_out);
            chk("rnd_ir_capture", {59'd0, ir_out}, 64'h05);
            chk("rnd_ir", {59'd0, ir}, {59'd0, ir_sel});
            cap_base = cap_cnt; upd_base = upd_cnt;
            dr_scan(din, n, dout);
            if (ir_sel == 5'h11) exp_upd = exp_reg[40:0];
            chk("rnd_tdo", dout, exp_out);
            chk("rnd_upd_data", {23'd0, upd_data}, {23'd0, exp_upd});
            chk("rnd_cap_cnt", 64'(cap_cnt - cap_base), (ir_sel == 5'h11) ? 64'd1 : 64'd0);
            chk("rnd_upd_cnt", 64'(upd_cnt - upd_base), (ir_sel == 5'h11) ? 64'd1 : 64'd0);
        end

        // Random TMS walk, then five TMS=1 rises must land in Test-Logic-Reset.
        lo_h = 4; hi_h = 4;
        for (int i = 0; i < 40; i++) tck_step(1'($urandom()), 1'($urandom()), b);
        tms_reset();
        chk("walk_ir", {59'd0, ir}, 64'h01);

        // State latency from a TCK pin rise, TDO/OE latency from a TCK pin fall.
        tms = 1'b1;
        repeat (4) @(negedge clk);
        tck = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (tap_state !== 4'(RUN_TEST_IDLE)) begin lat = k; break; end
        end
        chk("rise_latency", 64'(lat), 64'd3);
        m_state = SELECT_DR_SCAN;
        repeat (4) @(negedge clk);
        tck = 1'b0;
        tck_step(1'b0, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (tdo_oe === 1'b1) begin lat = k; break; end
        end
        chk("fall_latency", 64'(lat), 64'd3);
        chk("fall_tdo", {63'd0, tdo}, 64'd1);
        tms_reset();

        // TRST coincident with a TCK rise in USER Shift-DR.
        ir_scan(5'h11, ir_out);
        upd_base = upd_cnt;
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        for (int i = 0; i < 4; i++) tck_step(1'b0, 1'($urandom()), b);
        tms = 1'b0;
        repeat (lo_h) @(negedge clk);
        trst_n = 1'b0;
        tck    = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (tap_state === 4'(TEST_LOGIC_RESET)) begin lat = k; break; end
        end
        chk("trst_latency_ok", {63'd0, (lat >= 1) && (lat <= 3)}, 64'd1);
        chk("trst_ir", {59'd0, ir}, 64'h01);
        chk("trst_oe", {63'd0, tdo_oe}, 64'd0);
        repeat (4) @(negedge clk);
        tck = 1'b0;
        trst_n = 1'b1;
        repeat (6) @(negedge clk);
        m_state = TEST_LOGIC_RESET;
        chk("trst_no_update", 64'(upd_cnt - upd_base), 64'd0);
        chk("trst_state", {60'd0, tap_state}, {60'd0, TEST_LOGIC_RESET});
        tms_reset();

        // Asynchronous rst_i while parked in USER Pause-DR.
        ir_scan(5'h11, ir_out);
        dr_scan({23'd0, 41'h0_DEAD_BEEF_1}, 41, dout);
        chk("pre_rst_upd", {23'd0, upd_data}, 64'h0_DEAD_BEEF_1);
        upd_base = upd_cnt;
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        for (int i = 0; i < 3; i++) tck_step(1'b0, 1'b1, b);
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_state", {60'd0, tap_state}, {60'd0, TEST_LOGIC_RESET});
        chk("arst_ir", {59'd0, ir}, 64'h01);
        chk("arst_tdo", {62'd0, tdo, tdo_oe}, 64'd0);
        chk("arst_upd_data", {23'd0, upd_data}, 64'd0);
        chk("arst_pulses", {62'd0, dr_capture, dr_update}, 64'd0);
        #10;
        rst = 1'b0;
        m_state = TEST_LOGIC_RESET;
        exp_upd = '0;
        repeat (4) @(negedge clk);
        chk("arst_no_update", 64'(upd_cnt - upd_base), 64'd0);
        tms_reset();
        dr_scan(64'd0, 32, dout);
        chk("idcode_after_rst", dout, 64'h04F5484D);

        chk("no_back_to_back", 64'(b2b_cnt), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
